// File: rtl/sprite_pkg.sv
// Shared sprite-pipeline types and constants.
//   rgb12_t     : packed {r,g,b} 4 bits each
//   pal_idx_t   : 4-bit palette index
//   KEY_MAGENTA : colour-key value treated as transparent
//   PAL_DEPTH   : number of palette entries
package sprite_pkg;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  typedef logic [3:0] pal_idx_t;

  localparam rgb12_t      KEY_MAGENTA = 12'hF0F;
  localparam int unsigned PAL_DEPTH   = 16;

endpackage

// File: rtl/palette_lookup_arbiter_if.sv
// Bus between the pixel requesters / palette ROM / compositor and the lookup arbiter.
//   req, req_index        : per-requester lookup requests and packed 4-bit indices
//   gnt, pal_index        : combinational grant and index presented to the palette ROM
//   pal_red/green/blue    : combinational palette ROM return
//   out_*                 : registered result stage with valid/ready handshake
// Modports: slave = arbiter side, master = environment side.
interface palette_lookup_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 3
);
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ*4-1:0] req_index;
  logic [NUM_REQ-1:0]   gnt;
  logic [3:0]           pal_index;
  logic [3:0]           pal_red;
  logic [3:0]           pal_green;
  logic [3:0]           pal_blue;
  logic                 out_valid;
  logic                 out_ready;
  logic [ID_W-1:0]      out_id;
  logic [3:0]           out_red;
  logic [3:0]           out_green;
  logic [3:0]           out_blue;
  logic                 out_transp;

  modport slave (
    input  req, req_index, pal_red, pal_green, pal_blue, out_ready,
    output gnt, pal_index, out_valid, out_id, out_red, out_green, out_blue, out_transp
  );

  modport master (
    output req, req_index, pal_red, pal_green, pal_blue, out_ready,
    input  gnt, pal_index, out_valid, out_id, out_red, out_green, out_blue, out_transp
  );
endinterface

// File: rtl/palette_lookup_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
//   i_req    : request vector
//   i_rr_ptr : slot granted last; search starts at i_rr_ptr+1 (mod NUM_REQ)
//   i_enable : when low no grant is issued
//   o_gnt    : one-hot grant (or zero)
//   o_slot   : binary number of the granted slot (0 when none)
//   o_valid  : a grant was issued
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 3
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_rr_ptr,
  input  logic               i_enable,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]    o_slot,
  output logic               o_valid
);
  localparam int unsigned SelW = $clog2(NUM_REQ);

  int unsigned w_idx;

  always_comb begin
    o_gnt   = '0;
    o_slot  = '0;
    o_valid = 1'b0;
    w_idx   = 0;
    // Offsets 1..NUM_REQ visit every slot once, ending at the last-granted one.
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      w_idx = (32'(i_rr_ptr) + off) % NUM_REQ;
      if (i_enable && !o_valid && i_req[w_idx[SelW-1:0]]) begin
        o_valid                 = 1'b1;
        o_gnt[w_idx[SelW-1:0]]  = 1'b1;
        o_slot                  = ID_W'(w_idx);
      end
    end
  end
endmodule

// File: rtl/palette_lookup_arbiter.sv
// Shares one combinational 16-entry palette among NUM_REQ requesters.
//   Clk   : rising-edge clock
//   Reset : synchronous active-high reset
//   bus   : requests, palette ROM port and one-deep registered result stage
// A result is registered one cycle after its grant with requester ID and colour-key flag.
module palette_lookup_arbiter
  import sprite_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned ID_W      = 3,
  parameter logic [11:0] KEY_COLOR = KEY_MAGENTA
) (
  input  logic                    Clk,
  input  logic                    Reset,
  palette_lookup_arbiter_if.slave bus
);
  localparam int unsigned IdxW = $clog2(PAL_DEPTH);

  logic                r_out_valid;
  logic [ID_W-1:0]     r_out_id;
  rgb12_t              r_color;
  logic                r_transp;
  logic [ID_W-1:0]     r_rr_ptr;

  logic                w_can_accept;
  logic [NUM_REQ-1:0]  w_gnt;
  logic [ID_W-1:0]     w_slot;
  logic                w_gnt_any;
  pal_idx_t            w_pal_index;
  rgb12_t              w_pal_rgb;
  logic                w_key_hit;

  assign w_can_accept = !r_out_valid || bus.out_ready;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .i_req    (bus.req),
    .i_rr_ptr (r_rr_ptr),
    .i_enable (w_can_accept && !Reset),
    .o_gnt    (w_gnt),
    .o_slot   (w_slot),
    .o_valid  (w_gnt_any)
  );

  always_comb begin
    w_pal_index = bus.req_index[IdxW-1:0];
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) w_pal_index = bus.req_index[i*IdxW +: IdxW];
    end
  end

  assign w_pal_rgb = '{r: bus.pal_red, g: bus.pal_green, b: bus.pal_blue};
  assign w_key_hit = (w_pal_rgb == KEY_COLOR);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_out_valid <= 1'b0;
      r_out_id    <= '0;
      r_color     <= '0;
      r_transp    <= 1'b0;
      r_rr_ptr    <= ID_W'(NUM_REQ - 1);
    end else if (w_gnt_any) begin
      // Covers the pop+grant case: the new result overwrites the one being popped.
      r_out_valid <= 1'b1;
      r_out_id    <= w_slot;
      r_color     <= w_pal_rgb;
      r_transp    <= w_key_hit;
      r_rr_ptr    <= w_slot;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.gnt        = w_gnt;
  assign bus.pal_index  = w_pal_index;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_id     = r_out_id;
  assign bus.out_red    = r_color.r;
  assign bus.out_green  = r_color.g;
  assign bus.out_blue   = r_color.b;
  assign bus.out_transp = r_transp;
endmodule

// File: tb/tb_palette_lookup_arbiter.sv
// Directed self-checking bench for palette_lookup_arbiter (NUM_REQ=4).
module tb_palette_lookup_arbiter;
  logic Clk;
  logic Reset;
  int   n_checks;
  int   n_errors;

  palette_lookup_arbiter_if #(.NUM_REQ(4), .ID_W(3)) bus ();

  palette_lookup_arbiter #(
    .NUM_REQ   (4),
    .ID_W      (3),
    .KEY_COLOR (12'hF0F)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Palette ROM model: index 0 = magenta key, 3 = red, 4 = grey, all others 123.
  logic [11:0] pal_rgb;
  always_comb begin
    case (bus.pal_index)
      4'h0:    pal_rgb = 12'hF0F;
      4'h3:    pal_rgb = 12'hF00;
      4'h4:    pal_rgb = 12'h777;
      default: pal_rgb = 12'h123;
    endcase
  end
  assign bus.pal_red   = pal_rgb[11:8];
  assign bus.pal_green = pal_rgb[7:4];
  assign bus.pal_blue  = pal_rgb[3:0];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic valid, input logic [2:0] id,
                           input logic [11:0] rgb, input logic transp);
    check({tag, ".valid"}, 32'(bus.out_valid), 32'(valid));
    check({tag, ".id"}, 32'(bus.out_id), 32'(id));
    check({tag, ".rgb"}, 32'({bus.out_red, bus.out_green, bus.out_blue}), 32'(rgb));
    check({tag, ".transp"}, 32'(bus.out_transp), 32'(transp));
  endtask

  // Round-robin scenario: slot0 idx5, slot1 idx0, slot2 idx3, slot3 idx4.
  int unsigned rr_seq [5]     = '{0, 1, 2, 3, 0};
  logic [11:0] slot_rgb [4]   = '{12'h123, 12'hF0F, 12'hF00, 12'h777};
  logic        slot_transp [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    Reset         = 1'b1;
    bus.req       = 4'b1111;
    bus.req_index = 16'h0000;
    bus.out_ready = 1'b1;

    // Reset with all requests asserted.
    @(negedge Clk); #1;
    check("rst_gnt", 32'(bus.gnt), 32'h0);
    @(posedge Clk); @(posedge Clk); #1;
    check_out("rst", 1'b0, 3'd0, 12'h000, 1'b0);
    @(negedge Clk);
    Reset   = 1'b0;
    bus.req = 4'b0000;

    // Single requester, slot 2 index 3 -> red.
    bus.req       = 4'b0100;
    bus.req_index = 16'h0300;
    #1;
    check("single_gnt", 32'(bus.gnt), 32'h4);
    check("single_pidx", 32'(bus.pal_index), 32'h3);
    @(posedge Clk); #1;
    check_out("single", 1'b1, 3'd2, 12'hF00, 1'b0);
    @(negedge Clk);
    bus.req = 4'b0000;
    #1;
    check("idle_gnt", 32'(bus.gnt), 32'h0);
    @(posedge Clk); #1;
    check("idle_valid", 32'(bus.out_valid), 32'h0);

    // Reset pulse to return rr_ptr to 3.
    @(negedge Clk); Reset = 1'b1;
    @(negedge Clk); Reset = 1'b0;

    // Round-robin with all requests held, no bubbles.
    bus.req       = 4'b1111;
    bus.req_index = 16'h4305;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge Clk);
      #1;
      check($sformatf("rr%0d_gnt", k), 32'(bus.gnt), 32'(1 << rr_seq[k]));
      @(posedge Clk); #1;
      check_out($sformatf("rr%0d", k), 1'b1, 3'(rr_seq[k]), slot_rgb[rr_seq[k]],
                slot_transp[rr_seq[k]]);
    end

    // Backpressure: held result slot 0, rr_ptr stays 0.
    @(negedge Clk);
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("bp%0d_gnt", k), 32'(bus.gnt), 32'h0);
      @(posedge Clk); #1;
      check_out($sformatf("bp%0d", k), 1'b1, 3'd0, 12'h123, 1'b0);
      @(negedge Clk);
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_gnt", 32'(bus.gnt), 32'h2);
    @(posedge Clk); #1;
    check_out("bp_release", 1'b1, 3'd1, 12'hF0F, 1'b1);

    // Reset while a result is stalled.
    @(negedge Clk);
    bus.out_ready = 1'b0;
    Reset         = 1'b1;
    #1;
    check("mrst_gnt", 32'(bus.gnt), 32'h0);
    @(posedge Clk); #1;
    check_out("mrst", 1'b0, 3'd0, 12'h000, 1'b0);
    @(negedge Clk);
    Reset         = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check("mrst_first_gnt", 32'(bus.gnt), 32'h1);
    @(posedge Clk); #1;
    check_out("mrst_first", 1'b1, 3'd0, 12'h123, 1'b0);

    // Requests dropped: stage drains.
    @(negedge Clk);
    bus.req = 4'b0000;
    @(posedge Clk); #1;
    check("drain_valid", 32'(bus.out_valid), 32'h0);

    // Empty stage accepts even with out_ready low.
    @(negedge Clk);
    bus.out_ready = 1'b0;
    bus.req       = 4'b0010;
    #1;
    check("empty_gnt", 32'(bus.gnt), 32'h2);
    @(posedge Clk); #1;
    check_out("empty", 1'b1, 3'd1, 12'hF0F, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
